texel_serializer: RTL
=====================

# texel_serializer

Transmit-side counterpart of the texel assembler. Accepts whole 168-bit triangle records (three vertices plus color) and emits them as a framed stream of 32-bit words. The frame format is FRAME_START, then six words per triangle, then FRAME_END. It sits between the triangle source (rasterizer front end / readback path) and the AHB-facing word FIFO.

## Interface
- FRAME_START, 32'd0: frame header word.
- FRAME_END, 32'd1: frame trailer word.
- TRI_W, 168: triangle record width.
- WORDS_PER_TRI, 6: words emitted per triangle.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- frame_open  in  1  request to start a frame; sampled only in IDLE.
- frame_close  in  1  request to end the current frame; sticky until honored.
- tri_data  in  168  triangle record.
- tri_valid  in  1  tri_data valid.
- tri_ready  out  1  triangle accepted this cycle when tri_valid & tri_ready.
- word_out  out  32  registered stream word.
- word_valid  out  1  word_out valid.
- word_ready  in  1  consumer accepts; a transfer happens when word_valid & word_ready.
- busy  out  1  high in every state except IDLE.
- tri_count  out  16  triangles sent in the current frame; saturates at 16'hFFFF.

## Operation
- States: IDLE, SEND_START, ACTIVE, SEND_TRI, SEND_END.
- IDLE: word_valid=0, tri_ready=0. On frame_open, load word_out=FRAME_START, clear tri_count, and go to SEND_START. frame_close in IDLE is ignored and not latched, except when it arrives together with frame_open, in which case it is latched.
- SEND_START: hold FRAME_START with word_valid=1 until the transfer, then go to ACTIVE.
- ACTIVE: word_valid=0, tri_ready=1 (combinational).
  - tri_valid: capture tri_data into the hold register, set word_idx=0, load word_out=tri[31:0], increment tri_count, go to SEND_TRI.
  - Otherwise, if close_pending: load FRAME_END, go to SEND_END.
  - tri_valid has priority over close_pending.
- SEND_TRI: word k = tri[32k+31:32k] for k=0..4; word 5 = {24'h0, tri[167:160]}.
  - Each transfer advances word_idx and loads the next word in the same edge.
  - The transfer of word 5 returns to ACTIVE.
  - Word order is least-significant first, matching the receiver's shift-down assembly.
- SEND_END: hold FRAME_END until the transfer, then clear close_pending and go to IDLE.
- close_pending: set by frame_close in any non-IDLE state (or together with an accepted frame_open). Cleared only on the FRAME_END transfer.
- While word_valid=1 and word_ready=0, word_out and word_valid are held stable (no retraction, no change).

## Timing
- Reset values: word_out=32'h0, word_valid=0, tri_ready=0, busy=0, tri_count=0, close_pending=0, word_idx=0. State is IDLE.
- rst mid-frame: returns to IDLE on the next edge. The partial triangle is discarded and no FRAME_END is emitted.
- frame_open at edge N: FRAME_START is valid from cycle N+1.
- Triangle accepted at edge N: word 0 is valid from N+1. With word_ready held high, word 5 transfers at edge N+6 and tri_ready reasserts in cycle N+6.
- Throughput: 7 cycles per triangle at full ready.
- Empty frame (open, then close with no triangles): exactly two words, FRAME_START then FRAME_END.
- tri_count saturates at 16'hFFFF and does not wrap.
- word_idx is 3 bits and never exceeds 5.

## Structure
- Shared package gpu_stream_pkg holds:
  - FRAME_START, FRAME_END, TRI_W, WORDS_PER_TRI.
  - The serializer state enum typedef.
  - A tri_t (logic [167:0]) typedef, also used by the assembler side.
- No sub-module. The 6:1 word select and the FSM live in one module. The block is a single always_ff for state/datapath plus an always_comb for next-state and tri_ready.

## Test plan
- Reset then frame_open. Send one triangle tri_data = 168'h{A5,...} with consecutive word patterns 32'h11111111..32'h55555555 and top byte 8'hAB, then frame_close. Required stream: 0, 11111111, 22222222, 33333333, 44444444, 55555555, 000000AB, 1. tri_count=1.
- word_ready toggled 1,0,0,1 repeatedly during a triangle: each word is held stable across stalls, no word is dropped or duplicated, and the total stays 6 payload words.
- frame_close asserted in the same cycle tri_valid is high in ACTIVE: the triangle is sent fully first, then FRAME_END; tri_ready stays low during SEND_TRI.
- Empty frame, with frame_open and frame_close in the same cycle: exactly the words 0 then 1, then busy=0.
- rst asserted in SEND_TRI after word 2: the next cycle has word_valid=0, busy=0, tri_count=0, and no FRAME_END.
- Back-to-back triangles with tri_valid held high and word_ready=1: 7-cycle cadence, and tri_count increments on each acceptance.

Source files
------------

// File: rtl/gpu_stream_pkg.sv
// Shared definitions for the triangle word-stream path (serializer and assembler sides).
// Holds frame markers, record geometry, serializer states and the word-select helper.
package gpu_stream_pkg;

    localparam logic [31:0] FRAME_START   = 32'd0;
    localparam logic [31:0] FRAME_END     = 32'd1;
    localparam int          TRI_W         = 168;
    localparam int          WORDS_PER_TRI = 6;

    typedef logic [TRI_W-1:0] tri_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_START,
        ACTIVE,
        SEND_TRI,
        SEND_END
    } ser_state_t;

    // Least-significant word first; the last word carries only the top 8 bits.
    function automatic logic [31:0] tri_word(input tri_t rec, input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = rec[31:0];
            3'd1:    w = rec[63:32];
            3'd2:    w = rec[95:64];
            3'd3:    w = rec[127:96];
            3'd4:    w = rec[159:128];
            default: w = {24'h0, rec[167:160]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/texel_serializer_if.sv
// Triangle-in / word-out handshake bundle for the texel serializer.
// slave is the serializer's view; master is the view of the block that feeds and drains it.
interface texel_serializer_if;
    import gpu_stream_pkg::*;

    logic        frame_open;
    logic        frame_close;
    tri_t        tri_data;
    logic        tri_valid;
    logic        tri_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic [15:0] tri_count;

    modport slave (
        input  frame_open, frame_close, tri_data, tri_valid, word_ready,
        output tri_ready, word_out, word_valid, busy, tri_count
    );

    modport master (
        output frame_open, frame_close, tri_data, tri_valid, word_ready,
        input  tri_ready, word_out, word_valid, busy, tri_count
    );

endinterface

// File: rtl/texel_serializer.sv
// Splits 168-bit triangle records into a framed stream of 32-bit words:
// FRAME_START, six words per triangle (LSW first), FRAME_END.
module texel_serializer
    import gpu_stream_pkg::*;
(
    input logic              clk,
    input logic              rst,
    texel_serializer_if.slave ser
);

    localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_TRI - 1);

    ser_state_t  state_q, state_d;
    logic [2:0]  word_idx_q, word_idx_d;
    tri_t        hold_q, hold_d;
    logic [31:0] word_out_q, word_out_d;
    logic [15:0] tri_count_q, tri_count_d;
    logic        close_pending_q, close_pending_d;
    logic        tri_ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            word_idx_q      <= 3'd0;
            hold_q          <= '0;
            word_out_q      <= 32'h0;
            tri_count_q     <= 16'h0;
            close_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_idx_q      <= word_idx_d;
            hold_q          <= hold_d;
            word_out_q      <= word_out_d;
            tri_count_q     <= tri_count_d;
            close_pending_q <= close_pending_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        word_idx_d      = word_idx_q;
        hold_d          = hold_q;
        word_out_d      = word_out_q;
        tri_count_d     = tri_count_q;
        close_pending_d = close_pending_q;
        tri_ready_c     = 1'b0;

        if (state_q != IDLE && ser.frame_close) close_pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                // A close is only remembered if it rides along with the open.
                if (ser.frame_open) begin
                    word_out_d      = FRAME_START;
                    tri_count_d     = 16'h0;
                    close_pending_d = ser.frame_close;
                    state_d         = SEND_START;
                end
            end
            SEND_START: begin
                if (ser.word_ready) state_d = ACTIVE;
            end
            ACTIVE: begin
                tri_ready_c = 1'b1;
                if (ser.tri_valid) begin
                    hold_d      = ser.tri_data;
                    word_idx_d  = 3'd0;
                    word_out_d  = tri_word(ser.tri_data, 3'd0);
                    tri_count_d = (tri_count_q == 16'hFFFF) ? tri_count_q : tri_count_q + 16'd1;
                    state_d     = SEND_TRI;
                end else if (close_pending_q) begin
                    word_out_d = FRAME_END;
                    state_d    = SEND_END;
                end
            end
            SEND_TRI: begin
                if (ser.word_ready) begin
                    if (word_idx_q == LAST_IDX) begin
                        word_idx_d = 3'd0;
                        state_d    = ACTIVE;
                    end else begin
                        word_idx_d = word_idx_q + 3'd1;
                        word_out_d = tri_word(hold_q, word_idx_q + 3'd1);
                    end
                end
            end
            SEND_END: begin
                if (ser.word_ready) begin
                    close_pending_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser.tri_ready  = tri_ready_c;
    assign ser.word_out   = word_out_q;
    assign ser.word_valid = (state_q == SEND_START) || (state_q == SEND_TRI) || (state_q == SEND_END);
    assign ser.busy       = (state_q != IDLE);
    assign ser.tri_count  = tri_count_q;

endmodule
